biquad_bank_tdm: RTL and testbench
==================================

# biquad_bank_tdm

Time-multiplexed, parametrised multi-band IIR filter bank: BANDS parallel bands, each a cascade of SECTIONS direct-form-I biquads, all sharing one multiply-accumulate datapath. It replaces fixed, per-band biquad instances with run-time-loadable coefficients, a valid/ready sample handshake and an arbitrary band/section count. It sits between the audio sample source and the per-band gain/output stage of the equaliser.

## Interface
- SIZE, 21, sample/coefficient word width (two's complement)
- PF, 15, fractional bits (Q(SIZE-PF-1).PF)
- BANDS, 3, number of output bands
- SECTIONS, 2, biquads cascaded per band
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- EN  in  1  run enable; 0 freezes the FSM and all state
- u  in  SIZE  input sample
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept sample
- y  out  BANDS*SIZE  band outputs, band b at [b*SIZE +: SIZE]
- out_valid  out  1  one-cycle strobe, y updated
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(BANDS*SECTIONS*5)  (band*SECTIONS+section)*5+k, k: 0=b0 1=b1 2=b2 3=a1 4=a2
- coef_data  in  SIZE  coefficient value

## Operation
- Section equation: y = b0·x + b1·x1 + b2·x2 + a1·y1 + a2·y2; a1/a2 stored pre-negated (added, never subtracted).
- Section s>0 of a band takes section s-1's new output as x; section 0 takes the captured sample.
- Per-section history x1,x2,y1,y2 (SIZE each), updated at that section's writeback: x2←x1, x1←x, y2←y1, y1←y.
- Products 2·SIZE bits; accumulator 2·SIZE+3 bits, cleared at each section start; result = acc >>> PF (floor), then narrowed to SIZE (see Configuration).
- FSM: IDLE (in_ready=1) → on in_valid&in_ready&EN capture u → CALC (band, section, tap counters; taps 0..4 MAC, tap 5 writeback) → DONE (out_valid=1, y registered) → IDLE.
- Coefficient writes honoured only in IDLE; writes in CALC/DONE are dropped.
- EN=0: FSM, counters, accumulator, history hold; in_ready=0; out_valid forced 0 and re-asserted when EN returns in DONE.
- Reset values: all history 0, y=0, out_valid=0, in_ready=0 during reset then 1, FSM IDLE, coefficients identity (b0=1<<PF, others 0), so default bank passes u to every band.

## Timing
- Capture at cycle 0; CALC occupies 6·BANDS·SECTIONS cycles; out_valid at cycle 6·BANDS·SECTIONS+1 (37 at defaults) with EN held 1.
- Each EN-low cycle delays out_valid by exactly one cycle.
- in_ready low from capture through DONE; next capture earliest the cycle after DONE; throughput one sample per 6·BANDS·SECTIONS+2 cycles.
- in_valid in CALC/DONE: ignored, not queued; source must hold.
- y stable between out_valid strobes.
- rst asserted mid-CALC: immediate abort, all reset values; partial sample discarded, no out_valid.

## Configuration
- BIQUAD_BANK_SAT_EN defined: every section result saturates to [-2^(SIZE-1), 2^(SIZE-1)-1] before writeback.
- Undefined: result truncated to low SIZE bits (two's-complement wrap); no saturation logic.

## Structure
- Shared package biquad_bank_pkg: FSM state encoding, tap index constants (B0..A2, WB=5), identity coefficient value, accumulator width function.
- Sub-module biquad_mac: multiplier, accumulator, shift, saturate/wrap; controlled by clear/accumulate/writeback strobes from the FSM.

## Test plan
- Reset, default coefficients, u=0x01000 → after 37 cycles out_valid=1, all three bands y=0x01000.
- Band 1 section 0: b0=0x04000, a1=0x04000; impulse u=0x08000 then zeros → band 1 outputs 0x04000, 0x02000, 0x01000; bands 0/2 follow input.
- Band 0 section 0 b0=0x10000 (2.0), u=0x0C0000 (24.0) → with BIQUAD_BANK_SAT_EN y0=0x0FFFFF; without, y0=0x180000 (−16.0).
- EN low for 5 cycles during CALC → out_valid at cycle 42, values unchanged from EN-always-high run.
- coef_we during CALC writing b0=0 → ignored, outputs still identity; same write in IDLE → next sample outputs 0 for that band.
- rst pulsed at cycle 10 of CALC → no out_valid, y=0, history cleared, coefficients identity; next sample processed as after power-up.

Source files
------------

// File: rtl/biquad_bank_pkg.sv
// -----------------------------------------------------------------------------
// biquad_bank_pkg
// Shared definitions for the time-multiplexed biquad filter bank:
//   - FSM state encoding
//   - tap sequence indices (B0..A2 are MAC taps, WB is the writeback slot)
//   - identity coefficient value (1.0 in Q.PF)
//   - accumulator width function
// No ports (package).
// -----------------------------------------------------------------------------
package biquad_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Tap order inside one section; the coefficient memory uses the same
    // order for k, so a tap index doubles as the coefficient offset.
    localparam logic [2:0] TAP_B0 = 3'd0;
    localparam logic [2:0] TAP_B1 = 3'd1;
    localparam logic [2:0] TAP_B2 = 3'd2;
    localparam logic [2:0] TAP_A1 = 3'd3;
    localparam logic [2:0] TAP_A2 = 3'd4;
    localparam logic [2:0] TAP_WB = 3'd5;

    localparam int NUM_COEF = 5;

    // Five full-width products plus headroom: 2*SIZE product bits + 3 guard bits.
    function automatic int acc_width(input int size);
        return 2 * size + 3;
    endfunction

    // 1.0 in a format with pf fractional bits.
    function automatic int ident_coef(input int pf);
        return 1 << pf;
    endfunction

endpackage

// File: rtl/biquad_bank_tdm_if.sv
// -----------------------------------------------------------------------------
// biquad_bank_tdm_if
// Sample / coefficient bus of the biquad bank.
//   EN        run enable (0 freezes the bank)
//   u         input sample, in_valid / in_ready handshake
//   y         band outputs, band b at [b*SIZE +: SIZE], out_valid strobe
//   coef_we / coef_addr / coef_data   coefficient write port
// Modports: master = sample source / controller, slave = filter bank.
// -----------------------------------------------------------------------------
interface biquad_bank_tdm_if #(
    parameter int SIZE     = 21,
    parameter int BANDS    = 3,
    parameter int SECTIONS = 2
);
    localparam int AW = $clog2(BANDS * SECTIONS * 5);

    logic                    EN;
    logic [SIZE-1:0]         u;
    logic                    in_valid;
    logic                    in_ready;
    logic [BANDS*SIZE-1:0]   y;
    logic                    out_valid;
    logic                    coef_we;
    logic [AW-1:0]           coef_addr;
    logic [SIZE-1:0]         coef_data;

    modport master (
        output EN, u, in_valid, coef_we, coef_addr, coef_data,
        input  in_ready, y, out_valid
    );

    modport slave (
        input  EN, u, in_valid, coef_we, coef_addr, coef_data,
        output in_ready, y, out_valid
    );
endinterface

// File: rtl/biquad_mac.sv
// -----------------------------------------------------------------------------
// biquad_mac
// Shared multiply-accumulate datapath of the biquad bank.
//   clk, rst   clock, asynchronous active-low reset
//   en_i       hold everything when low
//   clear_i    start of a section: load acc with this product
//   acc_i      add this product to acc
//   coef_i     coefficient operand (signed SIZE)
//   data_i     sample/history operand (signed SIZE)
//   result_o   (acc >>> PF) narrowed to SIZE bits, valid in the writeback slot
// Build option BIQUAD_BANK_SAT_EN: saturate the result instead of wrapping.
// -----------------------------------------------------------------------------
module biquad_mac
    import biquad_bank_pkg::*;
#(
    parameter int SIZE = 21,
    parameter int PF   = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic                   clear_i,
    input  logic                   acc_i,
    input  logic signed [SIZE-1:0] coef_i,
    input  logic signed [SIZE-1:0] data_i,
    output logic signed [SIZE-1:0] result_o
);
    localparam int ACC_W = acc_width(SIZE);

    logic signed [2*SIZE-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_q, acc_d;

    assign prod     = coef_i * data_i;
    assign prod_ext = $signed({{(ACC_W-2*SIZE){prod[2*SIZE-1]}}, prod});

    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            if (clear_i)
                acc_d = prod_ext;
            else if (acc_i)
                acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

`ifdef BIQUAD_BANK_SAT_EN
    logic signed [ACC_W-1:0] shifted;
    assign shifted = acc_q >>> PF;

    // Fits when every bit above the target sign bit equals that sign bit.
    always_comb begin
        if ((&shifted[ACC_W-1:SIZE-1]) || !(|shifted[ACC_W-1:SIZE-1]))
            result_o = shifted[SIZE-1:0];
        else if (shifted[ACC_W-1])
            result_o = {1'b1, {(SIZE-1){1'b0}}};
        else
            result_o = {1'b0, {(SIZE-1){1'b1}}};
    end
`else
    // Floor shift followed by two's-complement wrap is just a bit slice.
    assign result_o = acc_q[PF +: SIZE];
`endif

endmodule

// File: rtl/biquad_bank_tdm.sv
// -----------------------------------------------------------------------------
// biquad_bank_tdm
// BANDS parallel bands, each SECTIONS cascaded direct-form-I biquads, sharing
// one MAC. One sample is captured in IDLE, every (band, section) is evaluated
// in 6 cycles (5 MAC taps + writeback), then DONE presents all band outputs.
//   clk, rst   clock, asynchronous active-low reset
//   bus        biquad_bank_tdm_if.slave: EN, u/in_valid/in_ready,
//              y/out_valid, coef_we/coef_addr/coef_data
// Build option BIQUAD_BANK_SAT_EN (in biquad_mac): saturating section results.
// -----------------------------------------------------------------------------
module biquad_bank_tdm
    import biquad_bank_pkg::*;
#(
    parameter int SIZE     = 21,
    parameter int PF       = 15,
    parameter int BANDS    = 3,
    parameter int SECTIONS = 2
) (
    input  logic              clk,
    input  logic              rst,
    biquad_bank_tdm_if.slave  bus
);
    localparam int NSEC  = BANDS * SECTIONS;
    localparam int NCOEF = NSEC * NUM_COEF;
    localparam int AW    = $clog2(NCOEF);
    localparam int BW    = (BANDS > 1)    ? $clog2(BANDS)    : 1;
    localparam int SW    = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
    localparam int SIW   = (NSEC > 1)     ? $clog2(NSEC)     : 1;

    state_e                 state_q, state_d;
    logic [BW-1:0]          band_q, band_d;
    logic [SW-1:0]          sec_q, sec_d;
    logic [2:0]             tap_q, tap_d;
    logic                   alive_q;             // low during and just after reset
    logic signed [SIZE-1:0] sample_q;            // captured input sample
    logic signed [SIZE-1:0] x_q;                 // input of the current section
    logic signed [SIZE-1:0] coef_q [NCOEF];
    logic signed [SIZE-1:0] x1_q [NSEC];
    logic signed [SIZE-1:0] x2_q [NSEC];
    logic signed [SIZE-1:0] y1_q [NSEC];
    logic signed [SIZE-1:0] y2_q [NSEC];
    logic [BANDS*SIZE-1:0]  y_w;

    logic                   in_ready, capture, calc, wb, coef_wr;
    logic                   last_sec, last_band;
    logic [SIW-1:0]         sec_idx;
    logic [2:0]             tap_k;
    logic [AW-1:0]          coef_idx;
    logic signed [SIZE-1:0] mac_data, mac_result;

    assign calc      = (state_q == ST_CALC);
    assign last_sec  = (sec_q == SW'(SECTIONS - 1));
    assign last_band = (band_q == BW'(BANDS - 1));
    assign capture   = bus.in_valid && in_ready;
    assign wb        = calc && bus.EN && (tap_q == TAP_WB);
    assign coef_wr   = bus.coef_we && bus.EN && (state_q == ST_IDLE);

    // Flattened section index and coefficient address; the writeback slot
    // has no coefficient, so its tap is clamped to keep the read in range.
    assign sec_idx  = SIW'(int'(band_q) * SECTIONS + int'(sec_q));
    assign tap_k    = (tap_q > TAP_A2) ? TAP_A2 : tap_q;
    assign coef_idx = AW'(int'(sec_idx) * NUM_COEF + int'(tap_k));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (bus.EN) begin
            case (state_q)
                ST_IDLE: if (capture) state_d = ST_CALC;
                ST_CALC: if (tap_q == TAP_WB && last_sec && last_band) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready      = alive_q && bus.EN && (state_q == ST_IDLE);
        bus.in_ready  = in_ready;
        bus.out_valid = bus.EN && (state_q == ST_DONE);
    end

    // ---------------- band / section / tap counters ----------------
    always_comb begin
        band_d = band_q;
        sec_d  = sec_q;
        tap_d  = tap_q;
        if (capture) begin
            band_d = '0;
            sec_d  = '0;
            tap_d  = TAP_B0;
        end else if (calc && bus.EN) begin
            if (tap_q == TAP_WB) begin
                tap_d = TAP_B0;
                if (last_sec) begin
                    sec_d  = '0;
                    band_d = last_band ? '0 : band_q + 1'b1;
                end else begin
                    sec_d = sec_q + 1'b1;
                end
            end else begin
                tap_d = tap_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            band_q <= '0;
            sec_q  <= '0;
            tap_q  <= TAP_B0;
        end else begin
            band_q <= band_d;
            sec_q  <= sec_d;
            tap_q  <= tap_d;
        end
    end

    // ---------------- coefficient memory ----------------
    // Kept in flops: every entry must come out of reset as an identity filter.
    genvar gi;
    generate
        for (gi = 0; gi < NCOEF; gi++) begin : g_coef
            localparam logic [SIZE-1:0] RST_VAL =
                ((gi % NUM_COEF) == 0) ? SIZE'(ident_coef(PF)) : '0;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    coef_q[gi] <= RST_VAL;
                else if (coef_wr && bus.coef_addr == AW'(gi))
                    coef_q[gi] <= bus.coef_data;
            end
        end
    endgenerate

    // ---------------- MAC operand select ----------------
    always_comb begin
        case (tap_q)
            TAP_B0:  mac_data = x_q;
            TAP_B1:  mac_data = x1_q[sec_idx];
            TAP_B2:  mac_data = x2_q[sec_idx];
            TAP_A1:  mac_data = y1_q[sec_idx];
            TAP_A2:  mac_data = y2_q[sec_idx];
            default: mac_data = '0;
        endcase
    end

    biquad_mac #(.SIZE(SIZE), .PF(PF)) u_mac (
        .clk      (clk),
        .rst      (rst),
        .en_i     (bus.EN),
        .clear_i  (calc && tap_q == TAP_B0),
        .acc_i    (calc && tap_q != TAP_WB),
        .coef_i   (coef_q[coef_idx]),
        .data_i   (mac_data),
        .result_o (mac_result)
    );

    // ---------------- sample, section chaining and history ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_q <= '0;
            x_q      <= '0;
            for (int i = 0; i < NSEC; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else begin
            if (capture) begin
                sample_q <= bus.u;
                x_q      <= bus.u;
            end
            if (wb) begin
                x2_q[sec_idx] <= x1_q[sec_idx];
                x1_q[sec_idx] <= x_q;
                y2_q[sec_idx] <= y1_q[sec_idx];
                y1_q[sec_idx] <= mac_result;
                // Next section chains this result; a new band restarts from the sample.
                x_q <= last_sec ? sample_q : mac_result;
            end
        end
    end

    // ---------------- band outputs ----------------
    // Updated only on the final writeback so y stays put between strobes.
    // Earlier bands read their last section's y1; the last band is being
    // written this very cycle, so it takes the MAC result directly.
    generate
        for (gi = 0; gi < BANDS; gi++) begin : g_band_out
            localparam int LAST = gi * SECTIONS + SECTIONS - 1;
            logic signed [SIZE-1:0] band_y_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    band_y_q <= '0;
                else if (wb && last_sec && last_band)
                    band_y_q <= (gi == BANDS - 1) ? mac_result : y1_q[LAST];
            end
            assign y_w[gi*SIZE +: SIZE] = band_y_q;
        end
    endgenerate

    assign bus.y = y_w;

endmodule

// File: tb/tb_biquad_bank_tdm.sv
// -----------------------------------------------------------------------------
// tb_biquad_bank_tdm
// Directed bench for biquad_bank_tdm with a behavioural filter-bank model.
// The model computes each biquad with plain integer arithmetic from the
// section equation; a negedge compare process checks every out_valid strobe
// against it and checks y holds between strobes. Directed tests add literal
// expectations. Honours BIQUAD_BANK_SAT_EN for the overflow case.
// -----------------------------------------------------------------------------
module tb_biquad_bank_tdm;
    localparam int SIZE     = 21;
    localparam int PF       = 15;
    localparam int BANDS    = 3;
    localparam int SECTIONS = 2;
    localparam int YW       = BANDS * SIZE;
    localparam int NC       = BANDS * SECTIONS * 5;
    localparam int AW       = $clog2(NC);
    localparam longint MAXV = (64'sd1 <<< (SIZE - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (SIZE - 1));

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    biquad_bank_tdm_if #(.SIZE(SIZE), .BANDS(BANDS), .SECTIONS(SECTIONS)) bif ();

    biquad_bank_tdm #(.SIZE(SIZE), .PF(PF), .BANDS(BANDS), .SECTIONS(SECTIONS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mc  [BANDS][SECTIONS][5];
    int mx1 [BANDS][SECTIONS];
    int mx2 [BANDS][SECTIONS];
    int my1 [BANDS][SECTIONS];
    int my2 [BANDS][SECTIONS];
    logic [YW-1:0] exp_q [$];
    logic [YW-1:0] held_y;

    function automatic int sx(input logic [SIZE-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic model_reset();
        for (int b = 0; b < BANDS; b++)
            for (int s = 0; s < SECTIONS; s++) begin
                for (int k = 0; k < 5; k++) mc[b][s][k] = (k == 0) ? (1 << PF) : 0;
                mx1[b][s] = 0; mx2[b][s] = 0; my1[b][s] = 0; my2[b][s] = 0;
            end
        exp_q.delete();
        held_y = '0;
    endtask

    task automatic model_coef(input int addr, input logic [SIZE-1:0] data);
        mc[addr / (SECTIONS * 5)][(addr / 5) % SECTIONS][addr % 5] = sx(data);
    endtask

    task automatic model_capture(input logic [SIZE-1:0] smp);
        logic [YW-1:0] e;
        e = '0;
        for (int b = 0; b < BANDS; b++) begin
            int x;
            x = sx(smp);
            for (int s = 0; s < SECTIONS; s++) begin
                longint acc, sh;
                logic [63:0] t;
                int r;
                acc = longint'(mc[b][s][0]) * x
                    + longint'(mc[b][s][1]) * mx1[b][s]
                    + longint'(mc[b][s][2]) * mx2[b][s]
                    + longint'(mc[b][s][3]) * my1[b][s]
                    + longint'(mc[b][s][4]) * my2[b][s];
                sh = acc >>> PF;
`ifdef BIQUAD_BANK_SAT_EN
                if (sh > MAXV)      r = int'(MAXV);
                else if (sh < MINV) r = int'(MINV);
                else                r = int'(sh);
`else
                t = sh;
                r = sx(t[SIZE-1:0]);
`endif
                mx2[b][s] = mx1[b][s];
                mx1[b][s] = x;
                my2[b][s] = my1[b][s];
                my1[b][s] = r;
                x = r;
            end
            e[b*SIZE +: SIZE] = SIZE'(x);
        end
        exp_q.push_back(e);
    endtask

    // ---------------- compare process ----------------
    logic [YW-1:0] cmp_e;
    always @(negedge clk) begin
        if (rst) begin
            if (bif.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    cmp_e = exp_q.pop_front();
                    for (int b = 0; b < BANDS; b++)
                        check($sformatf("model_band%0d", b),
                              64'(bif.y[b*SIZE +: SIZE]), 64'(cmp_e[b*SIZE +: SIZE]));
                    held_y = cmp_e;
                end
            end else begin
                check("y_hold", 64'(bif.y), 64'(held_y));
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bif.in_ready), 64'd0);
        check("rst_out_valid", 64'(bif.out_valid), 64'd0);
        check("rst_y", 64'(bif.y), 64'd0);
        #1 rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 64'(bif.in_ready), 64'd1);
    endtask

    task automatic wait_ready(output bit ok);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bif.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        ok = bif.in_ready;
        if (!ok) check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic coef_write(input int addr, input logic [SIZE-1:0] data);
        bit ok;
        wait_ready(ok);
        #1;
        bif.coef_we   = 1'b1;
        bif.coef_addr = AW'(addr);
        bif.coef_data = data;
        @(negedge clk);
        #1 bif.coef_we = 1'b0;
        model_coef(addr, data);
        $display("coef write addr=%0d data=0x%0h", addr, data);
    endtask

    // mode 0: plain, 1: EN low 5 cycles, 2: coef write in CALC,
    // 3: reset at cycle 10, 4: in_valid held through CALC
    task automatic send(input logic [SIZE-1:0] smp, input int mode,
                        output int lat, output logic [YW-1:0] yv);
        int cyc;
        bit seen, ok;
        yv = '0;
        lat = -2;
        wait_ready(ok);
        if (!ok) return;
        #1;
        bif.u        = smp;
        bif.in_valid = 1'b1;
        @(posedge clk);
        model_capture(smp);
        cyc = 1;
        #1 if (mode != 4) bif.in_valid = 1'b0;
        seen = 1'b0;
        while (!seen && cyc < 120) begin
            @(negedge clk);
            if (bif.out_valid) begin
                seen = 1'b1;
                yv   = bif.y;
            end else begin
                #1;
                case (mode)
                    1: begin
                        if (cyc == 5)  bif.EN = 1'b0;
                        if (cyc == 10) bif.EN = 1'b1;
                    end
                    2: begin
                        if (cyc == 5) begin
                            bif.coef_we   = 1'b1;
                            bif.coef_addr = '0;
                            bif.coef_data = '0;
                        end
                        if (cyc == 6) bif.coef_we = 1'b0;
                    end
                    3: begin
                        if (cyc == 10) begin
                            rst = 1'b0;
                            model_reset();
                        end
                        if (cyc == 12) rst = 1'b1;
                    end
                    default: ;
                endcase
                @(posedge clk);
                cyc++;
            end
        end
        #1 bif.in_valid = 1'b0;
        lat = seen ? cyc : -1;
        $display("sample u=0x%0h mode=%0d latency=%0d y=0x%0h", smp, mode, lat, yv);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    int lat;
    logic [YW-1:0] yv;

    initial begin
        bif.EN        = 1'b1;
        bif.u         = '0;
        bif.in_valid  = 1'b0;
        bif.coef_we   = 1'b0;
        bif.coef_addr = '0;
        bif.coef_data = '0;
        model_reset();

        // Default bank passes the sample to every band after 37 cycles
        do_reset();
        send(21'h01000, 0, lat, yv);
        check("t1_latency", 64'(lat), 64'(37));
        for (int b = 0; b < BANDS; b++)
            check($sformatf("t1_band%0d", b), 64'(yv[b*SIZE +: SIZE]), 64'h01000);

        // Band 1 one-pole: b0=0.5, a1=0.5, impulse response halves
        do_reset();
        coef_write(10, 21'h04000);
        coef_write(13, 21'h04000);
        send(21'h08000, 0, lat, yv);
        check("t2_s0_band1", 64'(yv[SIZE +: SIZE]), 64'h04000);
        check("t2_s0_band0", 64'(yv[0 +: SIZE]), 64'h08000);
        check("t2_s0_band2", 64'(yv[2*SIZE +: SIZE]), 64'h08000);
        send(21'h00000, 0, lat, yv);
        check("t2_s1_band1", 64'(yv[SIZE +: SIZE]), 64'h02000);
        check("t2_s1_band0", 64'(yv[0 +: SIZE]), 64'h00000);
        send(21'h00000, 0, lat, yv);
        check("t2_s2_band1", 64'(yv[SIZE +: SIZE]), 64'h01000);

        // Overflow: 2.0 * 24.0
        do_reset();
        coef_write(0, 21'h10000);
        send(21'h0C0000, 0, lat, yv);
`ifdef BIQUAD_BANK_SAT_EN
        check("t3_band0_sat", 64'(yv[0 +: SIZE]), 64'h0FFFFF);
`else
        check("t3_band0_wrap", 64'(yv[0 +: SIZE]), 64'h180000);
`endif
        check("t3_band1", 64'(yv[SIZE +: SIZE]), 64'h0C0000);

        // EN low for 5 cycles inside CALC
        do_reset();
        send(21'h01000, 1, lat, yv);
        check("t4_latency", 64'(lat), 64'(42));
        for (int b = 0; b < BANDS; b++)
            check($sformatf("t4_band%0d", b), 64'(yv[b*SIZE +: SIZE]), 64'h01000);

        // Coefficient write during CALC dropped, in IDLE honoured
        send(21'h02000, 2, lat, yv);
        check("t5_calc_write_band0", 64'(yv[0 +: SIZE]), 64'h02000);
        check("t5_latency", 64'(lat), 64'(37));
        coef_write(0, 21'h00000);
        send(21'h02000, 0, lat, yv);
        check("t5_idle_write_band0", 64'(yv[0 +: SIZE]), 64'h00000);
        check("t5_idle_write_band1", 64'(yv[SIZE +: SIZE]), 64'h02000);

        // Reset mid-CALC aborts the sample
        send(21'h03000, 3, lat, yv);
        check("t6_no_out_valid", 64'(lat), 64'(-1));
        check("t6_y_zero", 64'(bif.y), 64'd0);
        check("t6_ready", 64'(bif.in_ready), 64'd1);
        send(21'h01000, 0, lat, yv);
        check("t6_after_latency", 64'(lat), 64'(37));
        check("t6_after_band0", 64'(yv[0 +: SIZE]), 64'h01000);

        // in_valid held through CALC/DONE is not queued
        send(21'h00800, 4, lat, yv);
        check("t7_latency", 64'(lat), 64'(37));

        // Mixed coefficients, checked by the model only
        coef_write(0,  21'h06000);
        coef_write(1,  21'h02000);
        coef_write(2,  21'h1FF000);
        coef_write(3,  21'h03000);
        coef_write(4,  21'h1FF800);
        coef_write(25, 21'h10000);
        coef_write(28, 21'h1FC000);
        coef_write(16, 21'h01800);
        begin
            logic [SIZE-1:0] seq [6];
            seq = '{21'h04000, 21'h1F8000, 21'h07FFF, 21'h10000, 21'h1E0000, 21'h00000};
            for (int i = 0; i < 6; i++) begin
                send(seq[i], 0, lat, yv);
                check($sformatf("t8_latency%0d", i), 64'(lat), 64'(37));
            end
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
